// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and the write-back entry type
package wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    // One pending register-file write: destination register and its value.
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry FIFO with two ordered write ports and one read port
//   push0/push0_entry : first (older) write port
//   push1/push1_entry : second write port, lands behind push0 when both fire
//   pop               : advance the head
//   head              : entry at the read pointer
//   count             : occupancy
//   entry_valid       : per-slot occupied flags, entries: raw slot contents
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push0,
    input  wb_entry_t                   push0_entry,
    input  logic                        push1,
    input  wb_entry_t                   push1_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic [CW-1:0]               count,
    output logic [DEPTH-1:0]            entry_valid,
    output wb_entry_t [DEPTH-1:0]       entries
);

    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr_p1;
    logic [PW-1:0]          push1_idx;
    logic [1:0]             n_push;
    wb_entry_t [DEPTH-1:0]  slots;

    assign n_push    = {1'b0, push0} + {1'b0, push1};
    assign wr_ptr_p1 = wr_ptr + PW'(1);
    // The second port takes the slot after the first when both write together.
    assign push1_idx = push0 ? wr_ptr_p1 : wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(n_push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push0) begin
            slots[wr_ptr] <= push0_entry;
        end
        if (push1) begin
            slots[push1_idx] <= push1_entry;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [PW-1:0] offset;
        assign offset         = PW'(i) - rd_ptr;
        assign entry_valid[i] = ({1'b0, offset} < count);
    end

    assign head    = slots[rd_ptr];
    assign entries = slots;

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges MEM and ALU results into the register-file write port
//   mem_valid/mem_reg/mem_data/mem_ready : load path result handshake
//   alu_valid/alu_reg/alu_data/alu_ready : ALU result handshake
//   pend_reg1/pend_reg2 -> pend_hit1/pend_hit2 : outstanding-write query for decode
//   RegWrite/write_reg/write_data : registered register-file write
//   count : FIFO occupancy
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic [REG_W-1:0]  mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic [REG_W-1:0]  pend_reg1,
    input  logic [REG_W-1:0]  pend_reg2,
    output logic              pend_hit1,
    output logic              pend_hit2,
    output logic              RegWrite,
    output logic [REG_W-1:0]  write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic [CW-1:0]     count
);

    logic                   mem_stores;
    logic [CW-1:0]          free;
    logic                   push0;
    logic                   push1;
    logic                   pop;
    wb_entry_t              head;
    logic [DEPTH-1:0]       entry_valid;
    wb_entry_t [DEPTH-1:0]  entries;
    logic                   fifo_hit1;
    logic                   fifo_hit2;

    // Writes to r0 are architecturally discarded, so they never claim a slot.
    assign mem_stores = mem_valid && (mem_reg != '0);
    assign free       = CW'(DEPTH) - count;

    // ALU may take the last free slot only when MEM is not also claiming it;
    // MEM wins because it is the older instruction.
    assign mem_ready = (free != '0);
    assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !mem_stores);

    assign push0 = mem_valid && mem_ready && (mem_reg != '0);
    assign push1 = alu_valid && alu_ready && (alu_reg != '0);
    assign pop   = (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0       (push0),
        .push0_entry ('{rd: mem_reg, data: mem_data}),
        .push1       (push1),
        .push1_entry ('{rd: alu_reg, data: alu_data}),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .entry_valid (entry_valid),
        .entries     (entries)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            RegWrite <= pop;
            if (pop) begin
                write_reg  <= head.rd;
                write_data <= head.data;
            end
        end
    end

    // The write being driven this cycle has not reached the register file yet,
    // so it still counts as pending alongside the queued entries.
    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entries[i].rd == pend_reg1)) begin
                fifo_hit1 = 1'b1;
            end
            if (entry_valid[i] && (entries[i].rd == pend_reg2)) begin
                fifo_hit2 = 1'b1;
            end
        end
        pend_hit1 = (pend_reg1 != '0) && (fifo_hit1 || (RegWrite && (write_reg == pend_reg1)));
        pend_hit2 = (pend_reg2 != '0) && (fifo_hit2 || (RegWrite && (write_reg == pend_reg2)));
    end

endmodule
